// File: rtl/ad9122_spi_target_if.sv
// SPI pin bundle for the AD9122-style register target.
// master drives nCS/SCLK/SDI; slave (the target) drives SDO/SDO_OE.
interface ad9122_spi_target_if;
   logic SPI_nCS;
   logic SPI_SCLK;
   logic SPI_SDI;
   logic SPI_SDO;
   logic SPI_SDO_OE;

   modport master (
      output SPI_nCS,
      output SPI_SCLK,
      output SPI_SDI,
      input  SPI_SDO,
      input  SPI_SDO_OE
   );

   modport slave (
      input  SPI_nCS,
      input  SPI_SCLK,
      input  SPI_SDI,
      output SPI_SDO,
      output SPI_SDO_OE
   );
endinterface

// File: rtl/ad9122_spi_target.sv
// SPI register target for 16-bit R/W+addr7+data8 frames, oversampled on CLK.
// Ports: CLK/RST (sync, active high); spi (slave modport: nCS, SCLK, SDI in,
//   SDO/SDO_OE out); REG_ADDR/REG_RDATA fabric read port (1 CLK latency);
//   WR_STB/WR_ADDR/WR_DATA write report; FRAME_ERR short-frame pulse.
// Optional macro AD9122_SPI_TARGET_READBACK_EN enables SDO read replies.
module ad9122_spi_target #(
   parameter int         NUM_REGS    = 32,
   parameter logic [7:0] RESET_VAL   = 8'h00,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                        CLK,
   input  logic                        RST,
   ad9122_spi_target_if.slave          spi,
   input  logic [6:0]                  REG_ADDR,
   output logic [7:0]                  REG_RDATA,
   output logic                        WR_STB,
   output logic [6:0]                  WR_ADDR,
   output logic [7:0]                  WR_DATA,
   output logic                        FRAME_ERR
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] NREGS_W = 8'(NUM_REGS);
   localparam int SCW = $clog2(SYNC_STAGES + 2);
   localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INSTR,
      ST_DATA,
      ST_DONE
   } state_t;

   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic ncs_dly_q, ncs_dly_d;
   logic sclk_dly_q, sclk_dly_d;
   logic [SCW-1:0] settle_q, settle_d;
   logic armed_q, armed_d;
   state_t state_q, state_d;
   logic [4:0] bit_cnt_q, bit_cnt_d;
   logic [14:0] shift_in_q, shift_in_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];
   logic [7:0] rdata_q, rdata_d;
   logic wr_stb_q, wr_stb_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic frame_err_q, frame_err_d;
`ifdef AD9122_SPI_TARGET_READBACK_EN
   logic [7:0] shift_out_q, shift_out_d;
   logic sdo_oe_q, sdo_oe_d;
   logic sclk_fall;
`endif

   logic ncs_s, sclk_s, sdi_s;
   logic ncs_rise, ncs_fall, sclk_rise;
   logic [15:0] frame_w;

   assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign ncs_rise  = ncs_s & ~ncs_dly_q;
   assign ncs_fall  = ~ncs_s & ncs_dly_q;
   assign sclk_rise = sclk_s & ~sclk_dly_q;
`ifdef AD9122_SPI_TARGET_READBACK_EN
   assign sclk_fall = ~sclk_s & sclk_dly_q;
`endif
   // Bits received so far with the bit arriving on this rise appended.
   assign frame_w   = {shift_in_q, sdi_s};

   function automatic logic in_range(input logic [6:0] a);
      in_range = ({1'b0, a} < NREGS_W);
   endfunction

   function automatic logic [7:0] reg_rd(input logic [6:0] a);
      reg_rd = in_range(a) ? regs_q[a[AW-1:0]] : 8'h00;
   endfunction

   always_comb begin
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], spi.SPI_nCS};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SPI_SCLK};
      sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi.SPI_SDI};
      ncs_dly_d   = ncs_s;
      sclk_dly_d  = sclk_s;
      settle_d    = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1;
      // Arm only once the flushed chain shows nCS high, so a frame cut by
      // reset is not mistaken for a fresh nCS fall.
      armed_d     = armed_q |
                    ((settle_q == SETTLE_MAX) & ncs_s & ncs_dly_q);
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      regs_d      = regs_q;
      rdata_d     = reg_rd(REG_ADDR);
      wr_stb_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_err_d = 1'b0;
`ifdef AD9122_SPI_TARGET_READBACK_EN
      shift_out_d = shift_out_q;
      sdo_oe_d    = sdo_oe_q;
`endif

      if (ncs_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 5'd0;
         if (ncs_rise && bit_cnt_q != 5'd0 && bit_cnt_q < 5'd16)
            frame_err_d = 1'b1;
`ifdef AD9122_SPI_TARGET_READBACK_EN
         shift_out_d = 8'h00;
         sdo_oe_d    = 1'b0;
`endif
      end else if (ncs_fall && armed_q) begin
         state_d   = ST_INSTR;
         bit_cnt_d = 5'd0;
      end else if (sclk_rise &&
                   (state_q == ST_INSTR || state_q == ST_DATA)) begin
         shift_in_d = frame_w[14:0];
         bit_cnt_d  = bit_cnt_q + 5'd1;
         if (bit_cnt_q == 5'd7) begin
            state_d = ST_DATA;
`ifdef AD9122_SPI_TARGET_READBACK_EN
            // frame_w[7] is R/W, frame_w[6:0] the address at this point.
            if (frame_w[7]) begin
               shift_out_d = reg_rd(frame_w[6:0]);
               sdo_oe_d    = 1'b1;
            end
`endif
         end
         if (bit_cnt_q == 5'd15) begin
            state_d = ST_DONE;
            if (!frame_w[15]) begin
               wr_stb_d  = 1'b1;
               wr_addr_d = frame_w[14:8];
               wr_data_d = frame_w[7:0];
               if (in_range(frame_w[14:8]))
                  regs_d[frame_w[8+AW-1:8]] = frame_w[7:0];
            end
         end
`ifdef AD9122_SPI_TARGET_READBACK_EN
      end else if (sclk_fall && sdo_oe_q) begin
         shift_out_d = {shift_out_q[6:0], 1'b0};
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ncs_sync_q  <= '1;
         sclk_sync_q <= '0;
         sdi_sync_q  <= '0;
         ncs_dly_q   <= 1'b1;
         sclk_dly_q  <= 1'b0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 5'd0;
         shift_in_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= RESET_VAL;
         rdata_q     <= 8'h00;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= 7'd0;
         wr_data_q   <= 8'h00;
         frame_err_q <= 1'b0;
`ifdef AD9122_SPI_TARGET_READBACK_EN
         shift_out_q <= 8'h00;
         sdo_oe_q    <= 1'b0;
`endif
      end else begin
         ncs_sync_q  <= ncs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         sdi_sync_q  <= sdi_sync_d;
         ncs_dly_q   <= ncs_dly_d;
         sclk_dly_q  <= sclk_dly_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         regs_q      <= regs_d;
         rdata_q     <= rdata_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_err_q <= frame_err_d;
`ifdef AD9122_SPI_TARGET_READBACK_EN
         shift_out_q <= shift_out_d;
         sdo_oe_q    <= sdo_oe_d;
`endif
      end
   end

   assign REG_RDATA = rdata_q;
   assign WR_STB    = wr_stb_q;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = wr_data_q;
   assign FRAME_ERR = frame_err_q;
`ifdef AD9122_SPI_TARGET_READBACK_EN
   assign spi.SPI_SDO    = shift_out_q[7];
   assign spi.SPI_SDO_OE = sdo_oe_q;
`else
   assign spi.SPI_SDO    = 1'b0;
   assign spi.SPI_SDO_OE = 1'b0;
`endif

endmodule
